// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the shared memory port: fetch side, load/store side and the memory port itself.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned STRB_W = 8
);
  logic              ibus_valid;
  logic [ADDR_W-1:0] ibus_addr;
  logic              ibus_data_ok;
  logic [DATA_W-1:0] ibus_data;

  logic              dbus_valid;
  logic [ADDR_W-1:0] dbus_addr;
  logic [DATA_W-1:0] dbus_wdata;
  logic [STRB_W-1:0] dbus_strobe;
  logic [2:0]        dbus_size;
  logic              dbus_data_ok;
  logic [DATA_W-1:0] dbus_data;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_strobe;
  logic [2:0]        mem_size;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  ibus_valid, ibus_addr,
    output ibus_data_ok, ibus_data,
    input  dbus_valid, dbus_addr, dbus_wdata, dbus_strobe, dbus_size,
    output dbus_data_ok, dbus_data,
    output mem_valid, mem_addr, mem_wdata, mem_strobe, mem_size,
    input  mem_data_ok, mem_rdata
  );

  // Requester / memory environment view
  modport master (
    output ibus_valid, ibus_addr,
    input  ibus_data_ok, ibus_data,
    output dbus_valid, dbus_addr, dbus_wdata, dbus_strobe, dbus_size,
    input  dbus_data_ok, dbus_data,
    input  mem_valid, mem_addr, mem_wdata, mem_strobe, mem_size,
    output mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the core memory port between fetch (ibus) and load/store (dbus) requesters.
// dbus wins from IDLE; on completion the other requester is handed the port with no gap.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned STRB_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic                err_timeout
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  localparam logic [2:0] MSIZE4 = 3'd2;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             grant_i;
  logic             grant_d;
  logic             ibus_ok_c;
  logic             dbus_ok_c;
  logic [CNT_W-1:0] wdog_cnt;
  logic [CNT_W-1:0] wdog_cnt_nxt;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state, grant and response routing
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    ibus_ok_c = 1'b0;
    dbus_ok_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.dbus_valid)      grant_d = 1'b1;
        else if (bus.ibus_valid) grant_i = 1'b1;
      end
      S_BUSY_I: begin
        if (bus.mem_data_ok) begin
          ibus_ok_c = 1'b1;
          if (bus.dbus_valid) grant_d = 1'b1;
          else                state_nxt = S_IDLE;
        end
      end
      S_BUSY_D: begin
        if (bus.mem_data_ok) begin
          dbus_ok_c = 1'b1;
          if (bus.ibus_valid) grant_i = 1'b1;
          else                state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (grant_d) state_nxt = S_BUSY_D;
    if (grant_i) state_nxt = S_BUSY_I;
  end

  assign bus.ibus_data_ok = ibus_ok_c;
  assign bus.dbus_data_ok = dbus_ok_c;
  assign bus.ibus_data    = bus.mem_rdata;
  assign bus.dbus_data    = bus.mem_rdata;

  // Memory port request registers, loaded on each grant and held while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mem_valid  <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.mem_strobe <= '0;
      bus.mem_size   <= '0;
    end else begin
      bus.mem_valid <= (state_nxt != S_IDLE);
      if (grant_d) begin
        bus.mem_addr   <= bus.dbus_addr;
        bus.mem_wdata  <= bus.dbus_wdata;
        bus.mem_strobe <= bus.dbus_strobe;
        bus.mem_size   <= bus.dbus_size;
      end else if (grant_i) begin
        bus.mem_addr   <= bus.ibus_addr;
        bus.mem_wdata  <= '0;
        bus.mem_strobe <= '0;
        bus.mem_size   <= MSIZE4;
      end
    end
  end

  // Watchdog count: zero in IDLE and across every completion, saturating while stalled
  always_comb begin
    wdog_cnt_nxt = wdog_cnt;
    if (state == S_IDLE || bus.mem_data_ok) wdog_cnt_nxt = '0;
    else if (wdog_cnt != CNT_MAX)           wdog_cnt_nxt = wdog_cnt + CNT_W'(1);
  end

  // Watchdog register and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      wdog_cnt <= wdog_cnt_nxt;
      if (wdog_cnt_nxt == CNT_MAX) err_timeout <= 1'b1;
    end
  end

endmodule
